// File: rtl/mem_pkg.sv
// Shared line/address geometry and FSM state encoding for the data memory responder.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_pkg;

    localparam int LINE_BITS   = 256;
    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_array.sv
// DEPTH x 256-bit line store with one synchronous read/write port; contents are never reset.
// Latency: read data registered one edge after en with we=0; writes land on the same edge.
// Backpressure: none; a port access is taken on every cycle en is high.
module data_memory_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [LINE_BITS-1:0]       wdat,
    output logic [LINE_BITS-1:0]       rdat
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en && we) begin
            mem[idx] <= wdat;
        end
    end

    // Read register only updates on reads, so it holds the last read line across writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdat <= '0;
        end else if (en && !we) begin
            rdat <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding line memory model for a cache: accepts one read/write, acks after LATENCY cycles.
// Latency: ack_o pulses LATENCY cycles after the accepting edge; read data valid with the ack.
// Backpressure: none; requests are only taken in IDLE, inputs are ignored while BUSY/ACK.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [LINE_BITS-1:0]  data_i,
    output logic                  ack_o,
    output logic [LINE_BITS-1:0]  data_o
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = 6;

    typedef struct packed {
        logic                 write;
        logic [IDX_BITS-1:0]  idx;
        logic [LINE_BITS-1:0] dat;
    } req_t;

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt;
    req_t                req;
    logic                req_ld;
    logic                commit;
    logic                mem_en;

    // Offset bits and anything above the index alias freely onto the line store.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_BITS-1:OFFSET_BITS+IDX_BITS], addr_i[OFFSET_BITS-1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ld    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable_i) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_BITS'(LATENCY - 1);
                    req_ld    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_BITS'(1)) begin
                    state_nxt = ST_ACK;
                    cnt_nxt   = '0;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ack_o <= 1'b0;
            req   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack_o <= (state_nxt == ST_ACK);
            if (req_ld) begin
                req.write <= write_i;
                req.idx   <= addr_i[OFFSET_BITS +: IDX_BITS];
                req.dat   <= data_i;
            end
        end
    end

    // Gate with reset so an abort on the final BUSY edge never touches storage.
    assign mem_en = commit && rst_i;

    data_memory_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (mem_en),
        .we    (req.write),
        .idx   (req.idx),
        .wdat  (req.dat),
        .rdat  (data_o)
    );

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 10, meaning cycles from request acceptance to ack (legal range 2..63).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning number of 256-bit lines (power of two).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port enable_i  input  1  request valid from the cache.
REQ-006 The block SHALL have port write_i  input  1  1 = line write, 0 = line read.
REQ-007 The block SHALL have port addr_i  input  32  byte address; bits [4:0] ignored.
REQ-008 The block SHALL have port data_i  input  256  write line data.
REQ-009 The block SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port data_o  output  256  read line data.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, BUSY, ACK.
REQ-012 In IDLE, enable_i=1 at a rising edge SHALL accept the request: latch write_i, data_i and line index = addr_i[5 +: log2(DEPTH)], load counter with LATENCY-1, go to BUSY.
REQ-013 Upper address bits above the index SHALL be ignored (aliasing wrap-around, no error).
REQ-014 In BUSY, the counter SHALL decrement each cycle; on the edge where it reaches 1, the FSM SHALL go to ACK.
REQ-015 A request accepted at edge T SHALL see ack_o=1 during exactly the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-016 ack_o SHALL be a registered output, high only in ACK, and high for exactly one cycle per accepted request.
REQ-017 For a write, the latched line SHALL be committed to storage on the edge entering ACK, so any later-accepted read returns it.
REQ-018 For a read, data_o SHALL be loaded from storage on the edge entering ACK and be valid during the ack cycle.
REQ-019 data_o SHALL hold its value until the next read completes; writes SHALL NOT change data_o.
REQ-020 ACK SHALL always return to IDLE; the request visible during the ACK cycle SHALL NOT be accepted.
REQ-021 A request present in the first IDLE cycle after ACK SHALL be accepted at that edge, supporting back-to-back write-back then refill.
REQ-022 Changes to enable_i, write_i, addr_i or data_i during BUSY/ACK SHALL be ignored; a dropped enable_i SHALL NOT abort the transaction.
REQ-023 The block SHALL NOT check reads/writes for hazards beyond strict in-order single-outstanding processing.

Reset
REQ-024 With rst_i=0 at a rising edge: state=IDLE, counter=0, ack_o=0, data_o=0, latched request cleared.
REQ-025 Reset mid-BUSY SHALL abort the transaction: no storage write, no ack.
REQ-026 Storage contents SHALL NOT be reset (initialised only by bench preload).

Structure
REQ-027 Package mem_pkg SHALL hold LINE_BITS=256, ADDR_BITS=32, OFFSET_BITS=5 and the FSM state enum.
REQ-028 Line storage SHALL be one sub-module, data_memory_array (DEPTH x 256, one synchronous read/write port); FSM and counter stay in the top.

Verification
REQ-029 Preload line 3 with pattern A; read addr 0x00000060 at edge T -> ack_o=1 only in cycle T+10, data_o=A.
REQ-030 Write B to 0x00000060, then read it immediately after ack -> second ack 10 cycles after second acceptance, data_o=B.
REQ-031 Write-back of line 3 with enable held high, write_i dropped on the ack cycle, address switched to 0x00004060 (aliases line 3 at DEPTH=512) -> read accepted the cycle after ack, returns the just-written data, exactly two ack pulses.
REQ-032 Toggle addr_i/data_i/enable_i during BUSY -> original write committed to the original line, ack after 10 cycles.
REQ-033 Assert rst_i=0 five cycles into a write -> no ack, target line unchanged, ack_o=0 and data_o=0 after reset.
REQ-034 LATENCY=2 build, enable held high for 20 cycles -> ack pulse every 3 cycles, never two consecutive ack cycles.
